axi_4_lite_mst: RTL and testbench

AXI4-Lite master (initiator) that turns single-word command requests from local user logic into complete AXI4-Lite write or read transactions and returns the response status and read data. It is the initiator-side counterpart of the register-file slave. It drives the AW/W/B/AR/R channels directly. It issues one outstanding transaction at a time, and a watchdog flags slaves that never respond.

---
 rtl/axi_4_lite_mst_if.sv | 62 ++++++
 rtl/axi_4_lite_mst.sv | 149 ++++++++++++++
 tb/tb_axi_4_lite_mst.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_4_lite_mst_if.sv
// AXI4-Lite address/data/response channel bundle between an initiator and a target.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH (`C_AXI_DATA_WIDTH/8)
`endif

interface axi_4_lite_mst_if #(
    parameter int AW = `C_AXI_ADDR_WIDTH,
    parameter int DW = `C_AXI_DATA_WIDTH,
    parameter int SW = `C_AXI_STROBE_WIDTH
);
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY;
    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic [SW-1:0] M_AXI_WSTRB;
    logic          M_AXI_BVALID;
    logic          M_AXI_BREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_RVALID;
    logic          M_AXI_RREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;

    modport master (
        output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY,
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY,
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite initiator: one outstanding single-word read or write per user command,
// with a sticky watchdog flag for targets that stall in any channel phase.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH (`C_AXI_DATA_WIDTH/8)
`endif

module axi_4_lite_mst #(
    parameter int RESP_TIMEOUT_CYCLES = 256,
    localparam int AW = `C_AXI_ADDR_WIDTH,
    localparam int DW = `C_AXI_DATA_WIDTH,
    localparam int SW = `C_AXI_STROBE_WIDTH
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WRITE,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [DW-1:0] CMD_WDATA,
    input  logic [SW-1:0] CMD_WSTRB,
    output logic          RSP_VALID,
    output logic [1:0]    RSP_RESP,
    output logic [DW-1:0] RSP_RDATA,
    output logic          ERR_TIMEOUT,
    axi_4_lite_mst_if.master m_axi,
    output logic [2:0]    DEB_STATE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam logic [15:0] TMO = 16'(RESP_TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] wdog_cnt;
    logic        aw_done;
    logic        w_done;

    // A channel counts as done if its handshake already happened or happens this cycle.
    assign aw_done   = !m_axi.M_AXI_AWVALID || m_axi.M_AXI_AWREADY;
    assign w_done    = !m_axi.M_AXI_WVALID  || m_axi.M_AXI_WREADY;
    assign CMD_READY = (state == IDLE);
    assign DEB_STATE = state;

    assign m_axi.M_AXI_AWPROT = 3'b000;
    assign m_axi.M_AXI_ARPROT = 3'b000;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state               <= IDLE;
            m_axi.M_AXI_AWVALID <= 1'b0;
            m_axi.M_AXI_AWADDR  <= '0;
            m_axi.M_AXI_WVALID  <= 1'b0;
            m_axi.M_AXI_WDATA   <= '0;
            m_axi.M_AXI_WSTRB   <= '0;
            m_axi.M_AXI_BREADY  <= 1'b0;
            m_axi.M_AXI_ARVALID <= 1'b0;
            m_axi.M_AXI_ARADDR  <= '0;
            m_axi.M_AXI_RREADY  <= 1'b0;
            RSP_VALID           <= 1'b0;
            RSP_RESP            <= 2'b00;
            RSP_RDATA           <= '0;
            ERR_TIMEOUT         <= 1'b0;
            wdog_cnt            <= 16'd0;
        end else begin
            RSP_VALID <= 1'b0;

            // Watchdog only flags; the transaction keeps waiting for the target.
            if (state != IDLE) begin
                if (wdog_cnt != 16'hFFFF)
                    wdog_cnt <= wdog_cnt + 16'd1;
                if (TMO != 16'd0 && wdog_cnt == TMO - 16'd1)
                    ERR_TIMEOUT <= 1'b1;
            end

            case (state)
                IDLE: begin
                    wdog_cnt <= 16'd0;
                    if (CMD_VALID) begin
                        ERR_TIMEOUT <= 1'b0;
                        if (CMD_WRITE) begin
                            m_axi.M_AXI_AWADDR  <= CMD_ADDR;
                            m_axi.M_AXI_AWVALID <= 1'b1;
                            m_axi.M_AXI_WDATA   <= CMD_WDATA;
                            m_axi.M_AXI_WSTRB   <= CMD_WSTRB;
                            m_axi.M_AXI_WVALID  <= 1'b1;
                            state               <= WR_REQ;
                        end else begin
                            m_axi.M_AXI_ARADDR  <= CMD_ADDR;
                            m_axi.M_AXI_ARVALID <= 1'b1;
                            state               <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (m_axi.M_AXI_AWREADY)
                        m_axi.M_AXI_AWVALID <= 1'b0;
                    if (m_axi.M_AXI_WREADY)
                        m_axi.M_AXI_WVALID <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi.M_AXI_BREADY <= 1'b1;
                        state              <= WR_RESP;
                        wdog_cnt           <= 16'd0;
                    end
                end
                WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        m_axi.M_AXI_BREADY <= 1'b0;
                        RSP_RESP           <= m_axi.M_AXI_BRESP;
                        RSP_VALID          <= 1'b1;
                        state              <= IDLE;
                        wdog_cnt           <= 16'd0;
                    end
                end
                RD_REQ: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        m_axi.M_AXI_ARVALID <= 1'b0;
                        m_axi.M_AXI_RREADY  <= 1'b1;
                        state               <= RD_RESP;
                        wdog_cnt            <= 16'd0;
                    end
                end
                RD_RESP: begin
                    if (m_axi.M_AXI_RVALID) begin
                        m_axi.M_AXI_RREADY <= 1'b0;
                        RSP_RDATA          <= m_axi.M_AXI_RDATA;
                        RSP_RESP           <= m_axi.M_AXI_RRESP;
                        RSP_VALID          <= 1'b1;
                        state              <= IDLE;
                        wdog_cnt           <= 16'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Directed bench for axi_4_lite_mst against a small behavioural register-file target
// with configurable AW stall, W/B/R timing and read-response override.
`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH (`C_AXI_DATA_WIDTH/8)
`endif

module tb_axi_4_lite_mst;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic        err_timeout;
    logic [2:0]  deb_state;

    int n_chk = 0;
    int n_bad = 0;

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    axi_4_lite_mst_if bus ();

    axi_4_lite_mst #(.RESP_TIMEOUT_CYCLES(8)) dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .CMD_VALID    (cmd_valid),
        .CMD_READY    (cmd_ready),
        .CMD_WRITE    (cmd_write),
        .CMD_ADDR     (cmd_addr),
        .CMD_WDATA    (cmd_wdata),
        .CMD_WSTRB    (cmd_wstrb),
        .RSP_VALID    (rsp_valid),
        .RSP_RESP     (rsp_resp),
        .RSP_RDATA    (rsp_rdata),
        .ERR_TIMEOUT  (err_timeout),
        .m_axi        (bus),
        .DEB_STATE    (deb_state)
    );

    // Target configuration, written only by the stimulus process.
    int          cfg_aw_stall = 0;
    logic        cfg_w_always = 1'b0;
    int          cfg_b_delay = 0;
    int          cfg_r_delay = 0;
    logic        cfg_r_ovr = 1'b0;
    logic [31:0] cfg_r_data = '0;
    logic [1:0]  cfg_rresp = 2'b00;

    logic        aw_got, w_got, b_arm, r_arm;
    int          aw_wait, b_cnt, r_cnt, b_cur;
    logic [31:0] sl_addr, sl_wdata;
    logic [3:0]  sl_wstrb;
    logic [31:0] mem [16];
    logic        aw_hs, w_hs, ar_hs;

    assign bus.M_AXI_AWREADY = (aw_wait >= cfg_aw_stall);
    assign bus.M_AXI_WREADY  = cfg_w_always || aw_got;
    assign bus.M_AXI_ARREADY = 1'b1;
    assign bus.M_AXI_BRESP   = 2'b00;
    assign aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
    assign w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
    assign ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
    assign b_cur = b_arm ? b_cnt : cfg_b_delay;

    always @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_arm <= 1'b0; r_arm <= 1'b0;
            aw_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            sl_addr <= '0; sl_wdata <= '0; sl_wstrb <= '0;
            bus.M_AXI_BVALID <= 1'b0;
            bus.M_AXI_RVALID <= 1'b0;
            bus.M_AXI_RDATA  <= '0;
            bus.M_AXI_RRESP  <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1; sl_addr <= bus.M_AXI_AWADDR; aw_wait <= 0;
            end else if (bus.M_AXI_AWVALID) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_hs) begin
                w_got <= 1'b1; sl_wdata <= bus.M_AXI_WDATA; sl_wstrb <= bus.M_AXI_WSTRB;
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
                bus.M_AXI_BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                for (int i = 0; i < 4; i++)
                    if (sl_wstrb[i]) mem[sl_addr[5:2]][8*i +: 8] <= sl_wdata[8*i +: 8];
            end else if ((aw_got || aw_hs) && (w_got || w_hs) && !bus.M_AXI_BVALID) begin
                if (b_cur == 0) begin
                    bus.M_AXI_BVALID <= 1'b1; b_arm <= 1'b0;
                end else begin
                    b_cnt <= b_cur - 1; b_arm <= 1'b1;
                end
            end
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
                bus.M_AXI_RVALID <= 1'b0;
            end else if (ar_hs) begin
                bus.M_AXI_RDATA <= cfg_r_ovr ? cfg_r_data : mem[bus.M_AXI_ARADDR[5:2]];
                bus.M_AXI_RRESP <= cfg_rresp;
                if (cfg_r_delay == 0) bus.M_AXI_RVALID <= 1'b1;
                else begin r_arm <= 1'b1; r_cnt <= cfg_r_delay - 1; end
            end else if (r_arm) begin
                if (r_cnt == 0) begin bus.M_AXI_RVALID <= 1'b1; r_arm <= 1'b0; end
                else r_cnt <= r_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Trace results: cycle numbers are counted from the command-accept edge (edge 0).
    int          t_aw_end, t_w_end, t_ar_end, t_b_first, t_r_first, t_rsp, err_first;
    logic        c1_aw, c1_w, c1_ar, c1_err;
    logic        stab_bad, bready_early, bready_drop, rdy_at_rsp, rsp_after;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;

    // Called at a falling edge; returns at a falling edge one cycle after the response.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge S_AXI_ACLK);
        #1 cmd_valid = 1'b0;
        t_aw_end = 0; t_w_end = 0; t_ar_end = 0; t_b_first = 0; t_r_first = 0;
        t_rsp = 0; err_first = 0; stab_bad = 0; bready_early = 0; bready_drop = 0;
        for (int k = 1; k <= 200 && t_rsp == 0; k++) begin
            @(negedge S_AXI_ACLK);
            if (k == 1) begin
                c1_aw = bus.M_AXI_AWVALID; c1_w = bus.M_AXI_WVALID;
                c1_ar = bus.M_AXI_ARVALID; c1_err = err_timeout;
            end
            if (t_aw_end == 0 && !bus.M_AXI_AWVALID) t_aw_end = k;
            if (t_w_end == 0 && !bus.M_AXI_WVALID) t_w_end = k;
            if (t_ar_end == 0 && !bus.M_AXI_ARVALID) t_ar_end = k;
            if (bus.M_AXI_AWVALID && (bus.M_AXI_AWADDR != addr || bus.M_AXI_AWPROT != 3'b000)) stab_bad = 1;
            if (bus.M_AXI_WVALID && (bus.M_AXI_WDATA != data || bus.M_AXI_WSTRB != strb)) stab_bad = 1;
            if (bus.M_AXI_ARVALID && (bus.M_AXI_ARADDR != addr || bus.M_AXI_ARPROT != 3'b000)) stab_bad = 1;
            if (t_b_first != 0 && !bus.M_AXI_BREADY && !rsp_valid) bready_drop = 1;
            if (bus.M_AXI_BREADY && t_b_first == 0) t_b_first = k;
            if (bus.M_AXI_BREADY && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID)) bready_early = 1;
            if (bus.M_AXI_RREADY && t_r_first == 0) t_r_first = k;
            if (err_timeout && err_first == 0) err_first = k;
            if (rsp_valid) begin
                t_rsp = k; r_resp = rsp_resp; r_rdata = rsp_rdata; rdy_at_rsp = cmd_ready;
            end
        end
        if (t_rsp == 0) chk("rsp_timeout", 1'b0, 1'b1);
        @(negedge S_AXI_ACLK);
        rsp_after = rsp_valid;
    endtask

    logic rsp_seen;

    initial begin
        repeat (3) @(negedge S_AXI_ACLK);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_state", deb_state, 3'd0);
        chk("rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                           bus.M_AXI_BREADY, bus.M_AXI_RREADY, rsp_valid, err_timeout}, 7'b0);
        chk("rst_buses", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_ARADDR, bus.M_AXI_WSTRB}, 64'h0);
        chk("rst_rsp", {rsp_resp, rsp_rdata}, 34'h0);
        S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);

        // Write then read with the reference target timing.
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        chk("wr_c1_valids", {c1_aw, c1_w}, 2'b11);
        chk("wr_aw_end", t_aw_end, 2);
        chk("wr_w_end", t_w_end, 3);
        chk("wr_bready", t_b_first, 3);
        chk("wr_lat", t_rsp, 4);
        chk("wr_resp", r_resp, 2'b00);
        chk("wr_rdata_kept", r_rdata, 32'h0);
        chk("wr_pulse", rsp_after, 1'b0);
        chk("wr_rdy_at_rsp", rdy_at_rsp, 1'b1);
        chk("wr_stable", stab_bad, 1'b0);
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("rd_c1_ar", c1_ar, 1'b1);
        chk("rd_ar_end", t_ar_end, 2);
        chk("rd_rready", t_r_first, 2);
        chk("rd_lat", t_rsp, 3);
        chk("rd_data", r_rdata, 32'hDEADBEEF);
        chk("rd_resp", r_resp, 2'b00);

        // Partial strobe merge.
        issue(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
        issue(1'b1, 32'h8, 32'h11223344, 4'b0101);
        chk("strb_wr_rdata_kept", r_rdata, 32'hDEADBEEF);
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        chk("strb_rd_data", r_rdata, 32'hFF22FF44);

        // AWREADY held low five cycles while W is accepted at once.
        cfg_aw_stall = 5; cfg_w_always = 1'b1;
        issue(1'b1, 32'hC, 32'hCAFEF00D, 4'hF);
        chk("stall_w_end", t_w_end, 2);
        chk("stall_aw_end", t_aw_end, 7);
        chk("stall_bready", t_b_first, 7);
        chk("stall_bready_early", bready_early, 1'b0);
        chk("stall_stable", stab_bad, 1'b0);
        chk("stall_lat", t_rsp, 8);

        // Zero-wait target: shortest write.
        cfg_aw_stall = 0;
        issue(1'b1, 32'h10, 32'h12345678, 4'hF);
        chk("min_aw_end", t_aw_end, 2);
        chk("min_w_end", t_w_end, 2);
        chk("min_lat", t_rsp, 3);
        cfg_w_always = 1'b0;

        // Stub read with SLVERR.
        cfg_r_ovr = 1'b1; cfg_r_data = 32'hA5A5A5A5; cfg_rresp = 2'b10;
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        chk("err_rd_resp", r_resp, 2'b10);
        chk("err_rd_data", r_rdata, 32'hA5A5A5A5);
        chk("err_rd_pulse", rsp_after, 1'b0);
        cfg_r_ovr = 1'b0; cfg_rresp = 2'b00;

        // BVALID withheld 20 cycles with an 8-cycle watchdog.
        cfg_b_delay = 20;
        issue(1'b1, 32'h14, 32'h00000055, 4'hF);
        chk("tmo_bready", t_b_first, 3);
        chk("tmo_err_cycle", err_first, 11);
        chk("tmo_bready_held", bready_drop, 1'b0);
        chk("tmo_lat", t_rsp, 24);
        chk("tmo_sticky", err_timeout, 1'b1);
        cfg_b_delay = 0;
        issue(1'b0, 32'h14, 32'h0, 4'h0);
        chk("tmo_clear", c1_err, 1'b0);
        chk("tmo_rd_data", r_rdata, 32'h00000055);

        // Asynchronous reset while waiting in RD_RESP.
        cfg_r_delay = 50;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
        @(posedge S_AXI_ACLK);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge S_AXI_ACLK);
        chk("rr_state", deb_state, 3'd4);
        chk("rr_rready", bus.M_AXI_RREADY, 1'b1);
        #2 S_AXI_ARESETN = 1'b0;
        #1;
        chk("rr_rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                              bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 5'b0);
        chk("rr_rst_state", deb_state, 3'd0);
        chk("rr_rst_ready", cmd_ready, 1'b1);
        chk("rr_rst_rdata", rsp_rdata, 32'h0);
        rsp_seen = rsp_valid;
        repeat (2) begin @(negedge S_AXI_ACLK); rsp_seen |= rsp_valid; end
        S_AXI_ARESETN = 1'b1;
        cfg_r_delay = 0;
        repeat (3) begin @(negedge S_AXI_ACLK); rsp_seen |= rsp_valid; end
        chk("rr_no_rsp", rsp_seen, 1'b0);
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("rr_after_lat", t_rsp, 3);
        chk("rr_after_data", r_rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
